// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - MIPS opcode / funct constants used by the hazard decode
//   - fwd_sel_e : E-stage operand source (REGFILE / FROM_M / FROM_W)
//   - mdu_state_e : multiply/divide tracker states
//   - helpers: is_load() opcode decode, fwd_select() forwarding priority
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        REGFILE = 2'd0,
        FROM_M  = 2'd1,
        FROM_W  = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_load(input logic [5:0] op);
        logic hit;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: hit = 1'b1;
            default:                             hit = 1'b0;
        endcase
        return hit;
    endfunction

    // M-stage result is younger than W-stage, so it wins when both match.
    function automatic fwd_sel_e fwd_select(input logic       we_m,
                                            input logic [4:0] wba_m,
                                            input logic       we_w,
                                            input logic [4:0] wba_w,
                                            input logic [4:0] field);
        fwd_sel_e sel;
        if (we_m && (wba_m != 5'd0) && (wba_m == field)) begin
            sel = FROM_M;
        end else if (we_w && (wba_w != 5'd0) && (wba_w == field)) begin
            sel = FROM_W;
        end else begin
            sel = REGFILE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_tracker.sv
// mdu_tracker: busy tracker for the multi-cycle multiply/divide unit.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start_mult : mult/multu present in E (loads MULT_CYCLES)
//   start_div  : div/divu present in E (loads DIV_CYCLES)
//   busy       : high while an MDU operation is in flight
// Starts arriving while already BUSY are ignored.
module mdu_tracker
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start_mult) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(MULT_CYCLES);
                end else if (start_div) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(DIV_CYCLES);
                end
            end
            BUSY: begin
                // cnt counts the busy cycles still to come, including this one.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state_reg == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage MIPS pipeline.
// Decodes the D/E/M instruction words and produces:
//   stall            : freeze PC and F/D (drives En low)
//   clear_E          : flush D/E to a bubble (equal to stall)
//   fwd_rs_E/rt_E    : E operand source, 0=regfile 1=M result 2=W result
//   mdu_busy         : multiply/divide in progress
// Inputs: clk, rst (sync, active high), Instr_D/E/M, WBA_E/M/W, we_E/M/W.
// Optional MDU tracking and MDU stalls are built only when HAZARD_MDU_EN
// is defined; otherwise mdu_busy is 0 and MDU instructions never stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr_D,
    input  logic [31:0] Instr_E,
    input  logic [31:0] Instr_M,
    input  logic [4:0]  WBA_E,
    input  logic [4:0]  WBA_M,
    input  logic [4:0]  WBA_W,
    input  logic        we_E,
    input  logic        we_M,
    input  logic        we_W,
    output logic        stall,
    output logic        clear_E,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        mdu_busy
);

    logic [5:0] op_d, funct_d, op_e, op_m;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;

    assign op_d    = Instr_D[31:26];
    assign rs_d    = Instr_D[25:21];
    assign rt_d    = Instr_D[20:16];
    assign funct_d = Instr_D[5:0];
    assign op_e    = Instr_E[31:26];
    assign rs_e    = Instr_E[25:21];
    assign rt_e    = Instr_E[20:16];
    assign op_m    = Instr_M[31:26];

    // Load-use: the loaded value is not available until after M.
    logic load_use;
    assign load_use = is_load(op_e) && (WBA_E != 5'd0) &&
                      ((WBA_E == rs_d) || (WBA_E == rt_d));

    // Branches resolve in D, so any producer still in E (or a load in M)
    // cannot be forwarded in time.
    logic is_br_cmp, is_jr, rs_hit, rt_hit, branch_hz, load_m;
    assign load_m    = is_load(op_m);
    assign is_br_cmp = (op_d == OP_BEQ) || (op_d == OP_BNE);
    assign is_jr     = (op_d == OP_RTYPE) && (funct_d == FN_JR);
    assign rs_hit    = (rs_d != 5'd0) &&
                       ((we_E && (rs_d == WBA_E)) || (load_m && (rs_d == WBA_M)));
    assign rt_hit    = (rt_d != 5'd0) &&
                       ((we_E && (rt_d == WBA_E)) || (load_m && (rt_d == WBA_M)));
    assign branch_hz = (is_br_cmp && (rs_hit || rt_hit)) || (is_jr && rs_hit);

    logic mdu_hz;

`ifdef HAZARD_MDU_EN
    logic [5:0] funct_e;
    logic       start_mult, start_div, busy, d_is_mdu;

    assign funct_e    = Instr_E[5:0];
    assign start_mult = (op_e == OP_RTYPE) && ((funct_e == FN_MULT) || (funct_e == FN_MULTU));
    assign start_div  = (op_e == OP_RTYPE) && ((funct_e == FN_DIV)  || (funct_e == FN_DIVU));

    mdu_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_tracker (
        .clk        (clk),
        .rst        (rst),
        .start_mult (start_mult),
        .start_div  (start_div),
        .busy       (busy)
    );

    always_comb begin
        d_is_mdu = 1'b0;
        if (op_d == OP_RTYPE) begin
            case (funct_d)
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: d_is_mdu = 1'b1;
                default:                            d_is_mdu = 1'b0;
            endcase
        end
    end

    // A start in E counts too: the tracker only turns busy on the next edge.
    assign mdu_hz   = d_is_mdu && (busy || start_mult || start_div);
    assign mdu_busy = busy;
`else
    assign mdu_hz   = 1'b0;
    assign mdu_busy = 1'b0;
`endif

    // Fields that no hazard rule looks at.
    logic unused_bits;
    assign unused_bits = ^{clk, Instr_D[15:6], Instr_E[15:0], Instr_M[25:0]};

    fwd_sel_e fwd_rs_sel, fwd_rt_sel;
    assign fwd_rs_sel = fwd_select(we_M, WBA_M, we_W, WBA_W, rs_e);
    assign fwd_rt_sel = fwd_select(we_M, WBA_M, we_W, WBA_W, rt_e);

    // All control outputs are forced quiet during reset.
    assign stall    = ~rst & (load_use | branch_hz | mdu_hz);
    assign clear_E  = stall;
    assign fwd_rs_E = rst ? 2'd0 : fwd_rs_sel;
    assign fwd_rt_E = rst ? 2'd0 : fwd_rt_sel;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver computes the expected
// outputs from a behavioural model and queues them; a monitor on the
// falling edge pops and compares.
module tb_hazard_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Instr_D = '0, Instr_E = '0, Instr_M = '0;
    logic [4:0]  WBA_E = '0, WBA_M = '0, WBA_W = '0;
    logic        we_E = 1'b0, we_M = 1'b0, we_W = 1'b0;
    logic        stall, clear_E, mdu_busy;
    logic [1:0]  fwd_rs_E, fwd_rt_E;

    hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .Instr_D(Instr_D), .Instr_E(Instr_E), .Instr_M(Instr_M),
        .WBA_E(WBA_E), .WBA_M(WBA_M), .WBA_W(WBA_W),
        .we_E(we_E), .we_M(we_M), .we_W(we_W),
        .stall(stall), .clear_E(clear_E),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic       clear;
        logic [1:0] frs;
        logic [1:0] frt;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;
    int   busy_left = 0;   // model: remaining MDU busy cycles

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
        return w;
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        logic [31:0] w;
        w = {6'(op), 5'(rs), 5'(rt), 16'h0004};
        return w;
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
               (op == 6'h24) || (op == 6'h25);
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] f, input logic wm, input logic [4:0] am,
                                             input logic ww, input logic [4:0] aw);
        if (f != 0 && wm && am == f) return 2'd1;
        if (f != 0 && ww && aw == f) return 2'd2;
        return 2'd0;
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance the model.
    task automatic apply(input logic r, input logic [31:0] d, input logic [31:0] e,
                         input logic [31:0] m, input logic [4:0] wa_e, input logic [4:0] wa_m,
                         input logic [4:0] wa_w, input logic w_e, input logic w_m, input logic w_w);
        logic [5:0] op_d, fn_d, op_e, op_m;
        logic [4:0] rs_d, rt_d, rs_e, rt_e;
        logic       hz;
        logic       start_e;
        int         start_len;
        exp_t       x;
        @(posedge clk);
        #1;
        rst = r; Instr_D = d; Instr_E = e; Instr_M = m;
        WBA_E = wa_e; WBA_M = wa_m; WBA_W = wa_w; we_E = w_e; we_M = w_m; we_W = w_w;
        op_d = d[31:26]; fn_d = d[5:0]; rs_d = d[25:21]; rt_d = d[20:16];
        op_e = e[31:26]; rs_e = e[25:21]; rt_e = e[20:16]; op_m = m[31:26];
        hz = 1'b0;
        start_e = 1'b0;
        start_len = 0;
        if (is_load_op(op_e) && wa_e != 0 && (wa_e == rs_d || wa_e == rt_d)) hz = 1'b1;
        // Branch source registers: beq/bne read rs and rt, jr reads rs.
        if (op_d == 6'h04 || op_d == 6'h05 || (op_d == 6'h00 && fn_d == 6'h08)) begin
            for (int k = 0; k < 2; k++) begin
                logic [4:0] s;
                s = (k == 0) ? rs_d : rt_d;
                if (k == 1 && op_d == 6'h00) continue;
                if (s != 0 && ((w_e && s == wa_e) || (is_load_op(op_m) && s == wa_m))) hz = 1'b1;
            end
        end
`ifdef HAZARD_MDU_EN
        if (op_e == 6'h00 && e[5:0] >= 6'h18 && e[5:0] <= 6'h1B) begin
            start_e = 1'b1;
            start_len = (e[5:0] <= 6'h19) ? MULT_CYCLES : DIV_CYCLES;
        end
        if (op_d == 6'h00 && ((fn_d >= 6'h10 && fn_d <= 6'h13) || (fn_d >= 6'h18 && fn_d <= 6'h1B))
            && (busy_left > 0 || start_e)) hz = 1'b1;
`endif
        x.stall = r ? 1'b0 : hz;
        x.clear = r ? 1'b0 : hz;
        x.frs   = r ? 2'd0 : fwd_model(rs_e, w_m, wa_m, w_w, wa_w);
        x.frt   = r ? 2'd0 : fwd_model(rt_e, w_m, wa_m, w_w, wa_w);
        x.busy  = (busy_left > 0);
        exp_q.push_back(x);
        // State seen after the coming edge.
        if (r) busy_left = 0;
        else if (busy_left > 0) busy_left = busy_left - 1;
        else if (start_e) busy_left = start_len;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (txn %0d)", name, act, req, n_txn);
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle has a response.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("stall",    int'(stall),    int'(x.stall));
                check("clear_E",  int'(clear_E),  int'(x.clear));
                check("fwd_rs_E", int'(fwd_rs_E), int'(x.frs));
                check("fwd_rt_E", int'(fwd_rt_E), int'(x.frt));
                check("mdu_busy", int'(mdu_busy), int'(x.busy));
                $display("txn %0d: rst=%0b D=%08h E=%08h stall=%0b fwd=%0d/%0d busy=%0b",
                         n_txn, rst, Instr_D, Instr_E, stall, fwd_rs_E, fwd_rt_E, mdu_busy);
                n_txn++;
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        int r1, r2, r3;
        logic [5:0] loads [5];
        loads = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
        r1 = $urandom_range(0, 3); r2 = $urandom_range(0, 3); r3 = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
            0: return itype(int'(loads[$urandom_range(0, 4)]), r1, r2);
            1: return itype(6'h04, r1, r2);
            2: return itype(6'h05, r1, r2);
            3: return rtype(r1, 0, 0, 6'h08);
            4: return rtype(r1, r2, r3, 6'h20);
            5: return rtype(r1, r2, 0, 6'h18 + $urandom_range(0, 3));
            6: return rtype(r1, r2, r3, 6'h10 + $urandom_range(0, 3));
            7: return itype(6'h08, r1, r2);
            8: return 32'h0;
            default: return itype(6'h2B, r1, r2);
        endcase
    endfunction

    initial begin
        logic [31:0] nop, lw8, add9, lw3, beq3, divi, mflo, mult, addx;
        nop  = 32'h0;
        lw8  = itype(6'h23, 1, 8);
        add9 = rtype(8, 2, 9, 6'h20);
        lw3  = itype(6'h23, 1, 3);
        beq3 = itype(6'h04, 3, 0);
        divi = rtype(4, 5, 0, 6'h1A);
        mflo = rtype(0, 0, 7, 6'h12);
        mult = rtype(4, 5, 0, 6'h18);
        addx = rtype(5, 6, 7, 6'h20);

        // Initial reset with no checks, then a checked reset cycle with traffic.
        repeat (2) @(posedge clk);
        apply(1, beq3, lw3, lw3, 3, 3, 3, 1, 1, 1);
        apply(0, nop, nop, nop, 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, then clear once the lw reaches M.
        apply(0, add9, lw8, nop, 8, 0, 0, 1, 0, 0);
        apply(0, add9, nop, lw8, 0, 8, 0, 0, 1, 0);

        // Forwarding priority M > W > regfile.
        apply(0, nop, addx, nop, 0, 5, 5, 0, 1, 1);
        apply(0, nop, addx, nop, 0, 5, 5, 0, 0, 1);
        apply(0, nop, addx, nop, 0, 0, 0, 0, 1, 1);

        // Branch after load: two stall cycles.
        apply(0, beq3, lw3, nop, 3, 0, 0, 1, 0, 0);
        apply(0, beq3, nop, lw3, 0, 3, 0, 0, 1, 0);
        apply(0, beq3, nop, nop, 0, 0, 3, 0, 0, 1);

        // Divide in E with mflo waiting in D.
        apply(0, mflo, divi, nop, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIV_CYCLES + 1; i++) apply(0, mflo, nop, nop, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a multiply.
        apply(0, addx, mult, nop, 0, 0, 0, 0, 0, 0);
        apply(0, mflo, nop, nop, 0, 0, 0, 0, 0, 0);
        apply(0, mflo, nop, nop, 0, 5, 0, 0, 1, 0);
        apply(1, mflo, addx, nop, 0, 5, 6, 0, 1, 1);
        apply(0, mflo, nop, nop, 0, 0, 0, 0, 0, 0);

        // Load targeting $0 never stalls and never forwards.
        apply(0, rtype(0, 0, 9, 6'h20), itype(6'h23, 0, 0), nop, 0, 0, 0, 1, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            apply(($urandom_range(0, 49) == 0), rand_instr(), rand_instr(), rand_instr(),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
